// File: rtl/rf_scoreboard_pkg.sv
// Shared sizing and types for the register-file scoreboard.
package rf_scoreboard_pkg;

  localparam int unsigned NREG    = 32;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard_sb_counter.sv
// One per-register in-flight writer counter: saturating up/down with flush.
module sb_counter
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A flushed issue is killed, so it can neither count nor overflow.
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (flush_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == '1) err_o = 1'b1;
      else             cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_o = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/rf_scoreboard.sv
// ID-stage register scoreboard: tracks in-flight writers per GPR and raises stalls.
module rf_scoreboard
  import rf_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic            issue_we,
  input  logic [4:0]      issue_dest,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic            wb_we,
  input  logic [4:0]      wb_dest,
  input  logic            flush,
  output logic            src_stall,
  output logic            dest_full,
  output logic [NREG-1:0] busy_mask,
  output logic            sb_err
);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc, dec, err;
  logic             pend1, pend2;
  logic             sb_err_q;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      inc[r] = issue_valid && issue_we && (issue_dest == reg_idx_t'(r));
      dec[r] = wb_we && (wb_dest == reg_idx_t'(r));
    end
  end

  assign cnt[0] = '0;
  assign err[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk_i   (clk),
      .rst_i   (reset),
      .flush_i (flush),
      .inc_i   (inc[r]),
      .dec_i   (dec[r]),
      .cnt_o   (cnt[r]),
      .err_o   (err[r])
    );
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 0; r < NREG; r++) busy_mask[r] = (cnt[r] != '0);
  end

  // A lone writer retiring this cycle is forwarded from WB, so it no longer blocks.
  assign pend1 = cnt[rs1_addr] > {{(CNT_W-1){1'b0}}, dec[rs1_addr]};
  assign pend2 = cnt[rs2_addr] > {{(CNT_W-1){1'b0}}, dec[rs2_addr]};

  assign src_stall = (rs1_used && pend1) || (rs2_used && pend2);
  assign dest_full = issue_we && (issue_dest != '0) && (cnt[issue_dest] == '1)
                     && !dec[issue_dest];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     sb_err_q <= 1'b0;
    else if (|err) sb_err_q <= 1'b1;
  end

  assign sb_err = sb_err_q;

endmodule
